// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and ALU opcodes for the 5-stage CPU
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - selects one source operand from EX/MEM, MEM/WB or register-file data
module operand_fwd_mux #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd_data
);

  logic hit_exmem;
  logic hit_memwb;

  // x0 is never forwarded; the newer EX/MEM result wins over MEM/WB
  assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
  assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

  always_comb begin
    fwd_data = rf_data;
    if (hit_exmem) begin
      fwd_data = exmem_result;
    end else if (hit_memwb) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling and operand forwarding
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int ALU_CTRL_W = cpu_pkg::ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_use_imm,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_W-1:0]     memwb_result,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write
);

  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [DATA_W-1:0]     ex_rs1_data;
  logic [DATA_W-1:0]     ex_rs2_data;
  logic [DATA_W-1:0]     ex_imm;
  logic                  ex_use_imm;
  logic [DATA_W-1:0]     fwd_rs1;
  logic [DATA_W-1:0]     fwd_rs2;
  logic                  load_use;

  // rs2 is compared even for immediate forms: cheaper than decoding operand usage
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
  assign id_ready = !ex_stall && !load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_use_imm   <= 1'b0;
      alu_ctrl     <= ALU_CTRL_W'(ALU_ADD);
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (!ex_stall) begin
      if (load_use) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_rd        <= id_rd;
        ex_rs1_data  <= id_rs1_data;
        ex_rs2_data  <= id_rs2_data;
        ex_imm       <= id_imm;
        ex_use_imm   <= id_use_imm;
        alu_ctrl     <= id_alu_ctrl;
        ex_reg_write <= id_valid && id_reg_write;
        ex_mem_read  <= id_valid && id_mem_read;
        ex_mem_write <= id_valid && id_mem_write;
      end
    end
  end

  // forwarding is re-evaluated every cycle so held operands follow newer results
  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs              (ex_rs1),
    .rf_data         (ex_rs1_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs              (ex_rs2),
    .rf_data         (ex_rs2_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2)
  );

  assign alu_a         = fwd_rs1;
  assign alu_b         = ex_use_imm ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_stall, flush;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t scb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic ui, input logic [2:0] ctrl,
                       input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_imm = imm; id_use_imm = ui; id_alu_ctrl = ctrl;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic push_exp(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic [31:0] st, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.v = v; e.a = a; e.b = b; e.c = c; e.st = st; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw;
    scb.push_back(e);
  endtask

  task automatic scb_check(input string tag);
    exp_t e;
    if (scb.size() == 0) begin
      chk({tag, "_scb_empty"}, 32'd0, 32'd1);
    end else begin
      e = scb.pop_front();
      chk({tag, "_valid"}, ex_valid, e.v);
      chk({tag, "_reg_write"}, ex_reg_write, e.rw);
      chk({tag, "_mem_read"}, ex_mem_read, e.mr);
      chk({tag, "_mem_write"}, ex_mem_write, e.mw);
      if (e.v) begin
        chk({tag, "_alu_a"}, alu_a, e.a);
        chk({tag, "_alu_b"}, alu_b, e.b);
        chk({tag, "_alu_ctrl"}, alu_ctrl, e.c);
        chk({tag, "_store"}, ex_store_data, e.st);
        chk({tag, "_rd"}, ex_rd, e.rd);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    scb_check(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    ex_stall = 0; flush = 0;
    #2;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 3'b000);
    chk("rst_reg_write", ex_reg_write, 1'b0);
    chk("rst_ready", id_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // plain ADD, no hazards
    drive(1, 1, 32'd5, 2, 32'd7, 6, 0, 0, ALU_ADD, 1, 0, 0);
    push_exp(1, 32'd5, 32'd7, ALU_ADD, 32'd7, 6, 1, 0, 0);
    #1 chk("add_ready", id_ready, 1'b1);
    step("add");

    // both sources match rs1: EX/MEM wins, then MEM/WB, then RF
    drive(1, 3, 32'h33, 0, 0, 7, 32'h10, 1, ALU_OR, 1, 0, 0);
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hBB;
    push_exp(1, 32'hAA, 32'h10, ALU_OR, 32'd0, 7, 1, 0, 0);
    step("fwd_exmem");
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 32'hBB);
    memwb_reg_write = 0;
    #1 chk("fwd_none", alu_a, 32'h33);

    // x0 never forwarded
    drive(1, 0, 0, 0, 0, 5, 0, 0, ALU_AND, 1, 0, 0);
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFF;
    push_exp(1, 32'd0, 32'd0, ALU_AND, 32'd0, 5, 1, 0, 0);
    step("rs0");

    // invalid ID instruction: control bits gated off
    drive(0, 1, 32'd5, 2, 32'd7, 9, 0, 0, ALU_ADD, 1, 1, 1);
    exmem_reg_write = 0;
    push_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("invalid_gate");

    // load-use bubble
    drive(1, 1, 32'd5, 0, 0, 4, 32'd4, 1, ALU_ADD, 1, 1, 0);
    push_exp(1, 32'd5, 32'd4, ALU_ADD, 32'd0, 4, 1, 1, 0);
    step("load");
    drive(1, 5, 32'd9, 4, 32'h44, 8, 0, 0, ALU_SUB, 1, 0, 0);
    #1 chk("lu_ready_low", id_ready, 1'b0);
    push_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_bubble");
    chk("lu_ready_high", id_ready, 1'b1);
    exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'h1234;
    push_exp(1, 32'd9, 32'h1234, ALU_SUB, 32'h1234, 8, 1, 0, 0);
    step("lu_capture");

    // stall holds EX while forwarding keeps tracking
    drive(1, 2, 32'h22, 6, 32'h66, 0, 32'd8, 1, ALU_AND, 0, 0, 1);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) exmem_result = 32'h5678;
      #1 chk("stall_ready", id_ready, 1'b0);
      push_exp(1, 32'd9, (i == 2) ? 32'h5678 : 32'h1234, ALU_SUB,
               (i == 2) ? 32'h5678 : 32'h1234, 8, 1, 0, 0);
      step("stall_hold");
    end
    flush = 1;
    push_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_flush");
    flush = 0; ex_stall = 0;
    push_exp(1, 32'h22, 32'd8, ALU_AND, 32'h66, 0, 0, 0, 1);
    step("after_flush");

    // asynchronous reset mid-run
    drive(1, 1, 32'd5, 2, 32'd7, 3, 0, 0, ALU_SUB, 1, 0, 0);
    push_exp(1, 32'd5, 32'd7, ALU_SUB, 32'd7, 3, 1, 0, 0);
    step("pre_reset");
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ex_valid, 1'b0);
    chk("async_rst_alu_a", alu_a, 32'd0);
    chk("async_rst_alu_b", alu_b, 32'd0);
    chk("async_rst_reg_write", ex_reg_write, 1'b0);
    chk("scb_drained", scb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
